// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz VGA timing constants and the packed colour type.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  function automatic rgb_t to_rgb(input logic [11:0] val);
    return rgb_t'(val);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Tick-enabled shift register of configurable depth; depth 0 is a plain wire.
module vga_delay_line #(
  parameter int unsigned       Depth    = 1,
  parameter int unsigned       Width    = 3,
  parameter logic [Width-1:0]  ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o
);

  if (Depth == 0) begin : g_bypass
    logic unused_ok;
    assign unused_ok = ^{clk_i, rst_i, en_i};
    assign data_o    = data_i;
  end else begin : g_shift
    logic [Width-1:0] stage_q [Depth];
    logic [Width-1:0] stage_d [Depth];

    always_comb begin
      for (int unsigned i = 0; i < Depth; i++) begin
        stage_d[i] = stage_q[i];
      end
      if (en_i) begin
        stage_d[0] = data_i;
        for (int unsigned i = 1; i < Depth; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int unsigned i = 0; i < Depth; i++) begin
          stage_q[i] <= ResetVal;
        end
      end else begin
        stage_q <= stage_d;
      end
    end

    assign data_o = stage_q[Depth-1];
  end

endmodule

// File: rtl/vga_timing.sv
// 640x480@60 Hz VGA timing generator: scan coordinates out, 1-bit pixel in,
// sync and colour re-aligned to the pixel source latency.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned PIX_LAT = 1,
  parameter logic [11:0] FG_RGB  = 12'hFFF,
  parameter logic [11:0] BG_RGB  = 12'h000
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       pixel,
  output logic [9:0] pixel_x,
  output logic [8:0] pixel_y,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       frame_start
);

  localparam int unsigned    DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);
  localparam logic [9:0] HMax    = 10'(H_TOTAL - 1);
  localparam logic [9:0] VMax    = 10'(V_TOTAL - 1);
  localparam logic [9:0] HActEnd = 10'(H_ACTIVE);
  localparam logic [9:0] VActEnd = 10'(V_ACTIVE);
  localparam logic [9:0] HsStart = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HsEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VsStart = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VsEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]      h_cnt_q, h_cnt_d;
  logic [9:0]      v_cnt_q, v_cnt_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  rgb_t            rgb_q, rgb_d;
  logic            frame_start_q, frame_start_d;

  logic tick, h_wrap, v_wrap;
  logic active, hs_raw, vs_raw;
  logic act_dly, hs_dly, vs_dly;
  logic [2:0] dly_bundle;

  assign tick   = (div_cnt_q == DivMax);
  assign h_wrap = (h_cnt_q == HMax);
  assign v_wrap = (v_cnt_q == VMax);

  assign active = (h_cnt_q < HActEnd) && (v_cnt_q < VActEnd);
  assign hs_raw = !((h_cnt_q >= HsStart) && (h_cnt_q < HsEnd));
  assign vs_raw = !((v_cnt_q >= VsStart) && (v_cnt_q < VsEnd));

  always_comb begin
    div_cnt_d     = tick ? '0 : div_cnt_q + DivW'(1);
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    frame_start_d = 1'b0;
    if (tick) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 10'd1;
      if (h_wrap) begin
        v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
      end
      frame_start_d = h_wrap && v_wrap;
    end
  end

  // Delay active/syncs so they line up with the pixel returned PIX_LAT ticks later.
  vga_delay_line #(
    .Depth    (PIX_LAT),
    .Width    (3),
    .ResetVal (3'b011)
  ) u_delay (
    .clk_i  (HCLK),
    .rst_i  (HRESET),
    .en_i   (tick),
    .data_i ({active, hs_raw, vs_raw}),
    .data_o (dly_bundle)
  );

  assign {act_dly, hs_dly, vs_dly} = dly_bundle;

  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    rgb_d   = rgb_q;
    if (tick) begin
      hsync_d = hs_dly;
      vsync_d = vs_dly;
      if (!act_dly) begin
        rgb_d = '0;
      end else if (pixel) begin
        rgb_d = to_rgb(FG_RGB);
      end else begin
        rgb_d = to_rgb(BG_RGB);
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      div_cnt_q     <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pixel_x     = active ? h_cnt_q : '0;
  assign pixel_y     = active ? v_cnt_q[8:0] : '0;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vga_r       = rgb_q.r;
  assign vga_g       = rgb_q.g;
  assign vga_b       = rgb_q.b;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing.md
# vga_timing

Display-side timing generator for the Cortex-M0 AHB-Lite SoC. Produces the `pixel_x`/`pixel_y` scan coordinates that drive the SoC's triangle/output peripheral. Consumes the 1-bit `pixel` it returns, and emits 640x480@60 Hz VGA sync plus registered 4:4:4 colour outputs. Sits at the top level, between the SoC and the board VGA connector.

## Interface
Parameters:
- `CLK_DIV`, 2: HCLK cycles per pixel (50 MHz HCLK gives a 25 MHz pixel rate); legal range 1–8.
- `PIX_LAT`, 1: pixel ticks between a coordinate change and the matching `pixel` value; legal range 0–4.
- `FG_RGB`, 12'hFFF: colour output when `pixel`=1.
- `BG_RGB`, 12'h000: colour output when `pixel`=0 inside the active area.

Ports:
- `HCLK`, in, 1: the single clock.
- `HRESET`, in, 1: reset, synchronous, active-high.
- `pixel`, in, 1: pixel value from the SoC for the coordinates issued `PIX_LAT` ticks earlier.
- `pixel_x`, out, 10: active column, 0–639; 0 outside the active area.
- `pixel_y`, out, 9: active row, 0–479; 0 outside the active area.
- `hsync`, out, 1: horizontal sync, active-low.
- `vsync`, out, 1: vertical sync, active-low.
- `vga_r`, out, 4: red channel.
- `vga_g`, out, 4: green channel.
- `vga_b`, out, 4: blue channel.
- `frame_start`, out, 1: one-HCLK pulse at the start of each frame (`h`=0, `v`=0); intended for an M0 IRQ line.

## Operation
Tick divider:
- `div_cnt` counts 0 to `CLK_DIV`-1, then wraps.
- `tick` is asserted when `div_cnt`==`CLK_DIV`-1.
- With `CLK_DIV`=1, `tick` is always 1.

Counters (all state advances only on `tick`):
- `h_cnt` (10 bits) counts 0–799 and wraps to 0.
- `v_cnt` (10 bits) increments when `h_cnt` wraps from 799. It counts 0–524 and wraps to 0.
- `v_cnt`=524 together with `h_cnt`=799 wraps both counters to 0 on the same tick.

Horizontal timing: active 0–639, front porch 640–655, sync 656–751, back porch 752–799.

Vertical timing: active 0–479, front porch 480–489, sync 490–491, back porch 492–524.

Derived signals, all computed from the counters:
- `active` = (`h_cnt`<640) && (`v_cnt`<480).
- `hs_raw` is low for `h_cnt` in 656–751.
- `vs_raw` is low for `v_cnt` in 490–491.
- `pixel_x` = `active` ? `h_cnt` : 0.
- `pixel_y` = `active` ? `v_cnt[8:0]` : 0.

Alignment pipeline:
- `active`, `hs_raw` and `vs_raw` pass through a `PIX_LAT`-deep shift register that advances on `tick`.
- Colour is selected from the delayed `active` and the current `pixel`:
  - delayed `active`=0: RGB = 0.
  - delayed `active`=1, `pixel`=1: RGB = `FG_RGB`.
  - delayed `active`=1, `pixel`=0: RGB = `BG_RGB`.
- `FG_RGB`/`BG_RGB` split as [11:8] red, [7:4] green, [3:0] blue.
- `hsync`, `vsync` and RGB are registered on `tick`. Sync and colour therefore stay mutually aligned for any `PIX_LAT`.

`frame_start` is asserted for exactly one HCLK, on the `tick` cycle where the counters transition to (0,0).

## Timing
Reset values, asserted on the first HCLK edge with `HRESET`=1:
- `div_cnt`=0, `h_cnt`=0, `v_cnt`=0; shift register filled with `active`=0 and syncs=1.
- `hsync`=1, `vsync`=1, RGB=0, `frame_start`=0.
- `pixel_x`=0 and `pixel_y`=0; these follow from `h_cnt`=0, `v_cnt`=0.

After reset is released:
- The counters first advance on the `CLK_DIV`-th HCLK edge.
- The first visible pixel appears on RGB `PIX_LAT`+1 ticks after coordinate (0,0) is presented.

Outputs:
- `pixel_x`/`pixel_y` are combinational from registered counters, so they are glitch-free per HCLK.
- They are stable for `CLK_DIV` HCLKs per pixel.
- The SoC must present `pixel` before the next `tick` edge.

Frame period: 800×525 ticks = 420 000 ticks = 840 000 HCLK at `CLK_DIV`=2.

Reset mid-frame takes priority over `tick`. All state returns to reset values on that edge, and no `frame_start` pulse is generated by the reset itself.

With `PIX_LAT`=0 there is no shift stage; the raw signals feed the output registers directly.

## Structure
- Package `vga_pkg` holds the timing constants:
  - horizontal: `H_ACTIVE`, `H_FP`, `H_SYNC`, `H_BP`, `H_TOTAL`;
  - vertical: `V_ACTIVE`, `V_FP`, `V_SYNC`, `V_BP`, `V_TOTAL`;
  - typedef `rgb_t`: a 12-bit packed struct with fields r, g, b.
- One sub-module: `vga_delay_line`, a parameterised-depth, tick-enabled shift register. It is used for the {`active`, `hs_raw`, `vs_raw`} bundle.

## Test plan
- Reset held for 3 HCLKs with `CLK_DIV`=2:
  - `hsync`=`vsync`=1, RGB=0, `pixel_x`=`pixel_y`=0 throughout.
  - The first counter increment occurs 2 HCLKs after release.
- Free-run for one line: the `hsync` low pulse lasts exactly 96 ticks (192 HCLK) and starts at tick 656+`PIX_LAT`. The line period is 1600 HCLK.
- Free-run for two frames:
  - the `vsync` low pulse lasts exactly 2 lines (3200 HCLK);
  - `frame_start` pulses exactly once per 840 000 HCLK;
  - `pixel_y` never exceeds 479 and `pixel_x` never exceeds 639.
- Drive `pixel` = (`pixel_x`==100 && `pixel_y`==50) through a one-tick model delay with `PIX_LAT`=1. RGB=12'hFFF appears on exactly one tick per frame, aligned to column 100 relative to the `hsync` edge. All other active pixels show 0.
- `CLK_DIV`=1, `PIX_LAT`=0:
  - `tick` is constant 1;
  - the line is 800 HCLK;
  - RGB follows `pixel` with 1 HCLK of latency;
  - blanking forces RGB to 0 at `h_cnt`=640.
- Assert `HRESET` for 1 HCLK at `h_cnt`=700, `v_cnt`=300. The next edge gives counters=0 and syncs=1, and no `frame_start` pulse. The next frame's timing is identical to the post-power-up timing.
